// File: rtl/calc_pkg.sv
// calc_pkg: shared types, widths and helpers for the result BCD converter
package calc_pkg;
    typedef enum logic [1:0] {IDLE, ABS, SHIFT} conv_state_t;
    localparam int RESULT_W   = 16;
    localparam int BCD_DIGITS = 5;
    localparam int CONV_ITERS = 16;
    localparam int BCD_W      = 4*BCD_DIGITS;
    // Leading-zero blanking: a digit is shown if it or any higher digit is non-zero; units always shown
    function automatic logic [BCD_DIGITS-1:0] digit_mask(input logic [BCD_W-1:0] d);
        logic [BCD_DIGITS-1:0] m;
        m = '0;
        m[BCD_DIGITS-1] = |d[BCD_W-1 -: 4];
        for (int i = BCD_DIGITS-2; i >= 1; i--) m[i] = (|d[4*i +: 4]) | m[i+1];
        m[0] = 1'b1;
        return m;
    endfunction
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble correction cell, adds 3 to a BCD nibble that is 5 or more
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/result_bcd_conv.sv
// result_bcd_conv: sequential signed 16-bit to 5-digit BCD converter with blanking mask
module result_bcd_conv
    import calc_pkg::*;
(
    input  logic                  clk,
    input  logic                  nRST,
    input  logic                  start,
    input  logic [RESULT_W-1:0]   value,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [BCD_W-1:0]      bcd,
    output logic [BCD_DIGITS-1:0] digit_en
);
    conv_state_t           state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [RESULT_W-1:0]   val_q, val_d, mag_q, mag_d;
    logic [BCD_W-1:0]      sr_q, sr_d, sr_adj, sr_next, bcd_q, bcd_d;
    logic                  sign_q, sign_d, busy_q, busy_d, done_q, done_d, neg_q, neg_d;
    logic [BCD_DIGITS-1:0] en_q, en_d;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (.d(sr_q[4*g +: 4]), .q(sr_adj[4*g +: 4]));
    end

    assign sr_next = {sr_adj[BCD_W-2:0], mag_q[RESULT_W-1]};

    // Next-state logic: latch input, take magnitude, then shift one bit per cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        mag_d   = mag_q;
        sr_d    = sr_q;
        sign_d  = sign_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        neg_d   = neg_q;
        bcd_d   = bcd_q;
        en_d    = en_q;
        case (state_q)
            IDLE: if (start) begin
                val_d   = value;
                busy_d  = 1'b1;
                state_d = ABS;
            end
            ABS: begin
                sign_d  = val_q[RESULT_W-1];
                mag_d   = val_q[RESULT_W-1] ? ~val_q + 16'd1 : val_q;
                sr_d    = '0;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                sr_d  = sr_next;
                mag_d = mag_q << 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(CONV_ITERS-1)) begin
                    bcd_d   = sr_next;
                    neg_d   = sign_q;
                    en_d    = digit_mask(sr_next);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            val_q   <= '0;
            mag_q   <= '0;
            sr_q    <= '0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            neg_q   <= 1'b0;
            bcd_q   <= '0;
            en_q    <= 5'b00001;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            mag_q   <= mag_d;
            sr_q    <= sr_d;
            sign_q  <= sign_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            neg_q   <= neg_d;
            bcd_q   <= bcd_d;
            en_q    <= en_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign neg      = neg_q;
    assign bcd      = bcd_q;
    assign digit_en = en_q;
endmodule

// File: tb/tb_result_bcd_conv.sv
// tb_result_bcd_conv: randomized and directed checks against a behavioural converter model
module tb_result_bcd_conv;
    logic        clk = 0, nRST = 1, start = 0;
    logic [15:0] value = 0;
    logic        busy, done, neg;
    logic [19:0] bcd;
    logic [4:0]  digit_en;

    int checks = 0, errors = 0;
    bit run = 0;

    logic        exp_busy = 0, exp_done = 0, exp_neg = 0;
    logic [19:0] exp_bcd = 0;
    logic [4:0]  exp_en = 5'b00001;
    logic [15:0] m_val = 0;
    int          m_rem = 0;
    int          m_dones = 0;

    result_bcd_conv dut (
        .clk(clk), .nRST(nRST), .start(start), .value(value),
        .busy(busy), .done(done), .neg(neg), .bcd(bcd), .digit_en(digit_en)
    );

    always #5 clk = ~clk;

    function automatic int mag_of(input logic [15:0] v);
        return v[15] ? 65536 - int'(v) : int'(v);
    endfunction

    function automatic logic [19:0] ref_bcd(input logic [15:0] v);
        logic [19:0] r;
        int m, p;
        m = mag_of(v);
        p = 1;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'((m / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] ref_en(input logic [15:0] v);
        logic [4:0] r;
        int m, p;
        m = mag_of(v);
        r = 5'b00001;
        p = 10;
        for (int i = 1; i < 5; i++) begin
            r[i] = (m >= p);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference timing: conversion result appears 17 edges after the start-sample edge
    always @(posedge clk) begin
        if (nRST) begin
            m_rem = 0; exp_done = 0; exp_busy = 0; exp_neg = 0; exp_bcd = 0; exp_en = 5'b00001;
        end else begin
            exp_done = 0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    exp_done = 1; exp_busy = 0; m_dones++;
                    exp_neg = mag_of(m_val) != 0 && m_val[15];
                    exp_bcd = ref_bcd(m_val);
                    exp_en  = ref_en(m_val);
                end
            end else if (start) begin
                m_val = value; m_rem = 17; exp_busy = 1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) if (run) begin
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("done", 32'(done), 32'(exp_done));
        chk("neg", 32'(neg), 32'(exp_neg));
        chk("bcd", 32'(bcd), 32'(exp_bcd));
        chk("digit_en", 32'(digit_en), 32'(exp_en));
    end

    task automatic wait_done(output int k);
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic conv(input logic [15:0] v, input logic [19:0] eb, input logic en_, input logic [4:0] ee);
        int k;
        @(negedge clk); start = 1; value = v;
        @(negedge clk); start = 0; value = 16'($urandom);
        wait_done(k);
        chk("latency", 32'(k + 1), 32'd18);
        chk("dir_bcd", 32'(bcd), 32'(eb));
        chk("dir_neg", 32'(neg), 32'(en_));
        chk("dir_en", 32'(digit_en), 32'(ee));
    endtask

    initial begin
        int k, nd;
        chk("model_12345", 32'(ref_bcd(16'd12345)), 32'h12345);
        chk("model_8000", 32'(ref_bcd(16'h8000)), 32'h32768);
        chk("model_en907", 32'(ref_en(16'd907)), 32'b00111);
        chk("model_en0", 32'(ref_en(16'd0)), 32'b00001);
        repeat (2) @(negedge clk);
        run = 1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_bcd", 32'(bcd), 0);
        chk("rst_en", 32'(digit_en), 32'b00001);
        nRST = 0;
        conv(16'd12345, 20'h12345, 0, 5'b11111);
        conv(16'hFFFF, 20'h00001, 1, 5'b00001);
        conv(16'h8000, 20'h32768, 1, 5'b11111);
        conv(16'd0, 20'h00000, 0, 5'b00001);
        conv(16'd907, 20'h00907, 0, 5'b00111);
        // start while busy is ignored
        @(negedge clk); start = 1; value = 16'd100;
        @(negedge clk); start = 0;
        repeat (4) @(negedge clk);
        start = 1; value = 16'd55;
        @(negedge clk); start = 0;
        wait_done(k);
        chk("busy_ign_bcd", 32'(bcd), 32'h00100);
        nd = 0;
        repeat (20) begin @(negedge clk); if (done) nd++; end
        chk("busy_ign_single", 32'(nd), 0);
        // start held high across done restarts in the done cycle
        @(negedge clk); start = 1; value = 16'd321;
        @(negedge clk);
        wait_done(k);
        chk("held_bcd1", 32'(bcd), 32'h00321);
        value = 16'd4321;
        @(negedge clk);
        value = 16'd0;
        k = 1;
        while (done !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        chk("held_period", 32'(k), 32'd18);
        chk("held_bcd2", 32'(bcd), 32'h04321);
        start = 0;
        repeat (20) @(negedge clk);
        // reset mid-conversion
        @(negedge clk); start = 1; value = 16'd999;
        @(negedge clk); start = 0;
        repeat (7) @(negedge clk);
        nRST = 1;
        @(negedge clk); nRST = 0;
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_bcd", 32'(bcd), 0);
        chk("rstmid_en", 32'(digit_en), 32'b00001);
        nd = 0;
        repeat (20) begin @(negedge clk); if (done) nd++; end
        chk("rstmid_nodone", 32'(nd), 0);
        // randomized traffic with chatter while busy
        m_dones = 0;
        for (int c = 0; c < 24000 && m_dones < 1000; c++) begin
            @(negedge clk);
            start = ($urandom % 4) == 0;
            case ($urandom % 8)
                0: value = 16'h0000;
                1: value = 16'h8000;
                2: value = 16'hFFFF;
                3: value = 16'h7FFF;
                default: value = 16'($urandom);
            endcase
        end
        start = 0;
        k = 0;
        while (busy !== 1'b0 && k < 40) begin @(negedge clk); k++; end
        chk("final_idle", 32'(busy), 0);
        chk("rand_count_min", 32'(m_dones >= 700), 1);
        repeat (2) @(negedge clk);
        run = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/result_bcd_conv.md
# result_bcd_conv

Sequential signed-binary-to-BCD converter sitting directly downstream of the calculator controller. It takes the 16-bit two's-complement result and its completion strobe, then produces a sign flag, five packed BCD digits and a leading-zero blanking mask for the display driver. Conversion uses iterative shift-add-3 (double-dabble), one bit per clock, with a start/busy/done handshake.

## Interface
- No parameters. Widths are fixed by package constants: 16-bit input, 5 digits.
- clk  in  1  system clock; all logic on rising edge
- nRST  in  1  synchronous, active-high reset; the codebase port name is kept
- start  in  1  request; samples `value` when idle (wired to controller `complete`)
- value  in  16  two's-complement result (controller `display_output`)
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse; `bcd`, `neg` and `digit_en` are valid and updated
- neg  out  1  1 = result was negative
- bcd  out  20  digits [19:16]=10^4 … [3:0]=10^0, each 0–9
- digit_en  out  5  per-digit display enable; bit i corresponds to digit 10^i

## Operation
- States: IDLE, ABS, SHIFT.
- IDLE + start=1:
  - latch `value`
  - go to ABS
  - busy=1 from the next cycle
- IDLE + start=0: hold. Outputs keep their last converted values.
- ABS (1 cycle):
  - `neg` = value[15]
  - mag = value[15] ? (~value + 1) : value, taken as unsigned 16-bit
  - 0x8000 yields mag 32768, which is correct; no overflow case exists
  - clear the 20-bit BCD shift register; cnt = 0
  - go to SHIFT
- SHIFT (16 cycles), per cycle:
  - add 3 to every BCD nibble ≥ 5
  - shift {bcd_sr, mag} left by 1
  - cnt++
- SHIFT with cnt==15: on that edge perform the final shift, then:
  - load `bcd` with the result and `neg` with the latched sign
  - load `digit_en`: bit0 = 1; bit i (i=1..4) = (digit i ≠ 0) | digit_en[i+1], with digit_en[5] treated as 0
  - assert done for one cycle; busy=0; go to IDLE
- start while busy: ignored, not queued. Conversion continues undisturbed.
- start in the done cycle: accepted, because the state is already IDLE.
- `value` changes after sampling: no effect on the conversion in progress.
- Negative zero cannot occur. An input of 0 gives neg=0.

## Timing
- Reset values (nRST high at a rising edge):
  - state=IDLE, busy=0, done=0, neg=0
  - bcd=20'h00000, digit_en=5'b00001, cnt=0
  - internal registers cleared
- Reset mid-conversion: abort immediately and apply the reset values. No done pulse.
- Latency: start sampled at edge E0. ABS occupies E0→E1. Shifts occur on edges E2…E17.
- done is high in the cycle after E17: 17 cycles after the start-sample edge, 18 cycles from start assertion to done-visible.
- busy high in cycles E0+ through E17−; deasserted in the same cycle done is asserted.
- Maximum throughput: one conversion per 18 cycles (start held high continuously).
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `calc_pkg` holds:
  - `conv_state_t` enum (IDLE, ABS, SHIFT)
  - `RESULT_W = 16`, `BCD_DIGITS = 5`, `CONV_ITERS = 16`
  - `BCD_W = 4*BCD_DIGITS`
- One sub-module: `bcd_add3`, a combinational 4-bit "if ≥5 add 3" cell, instantiated 5× (generate loop) on the shift register nibbles.
- Top holds the FSM, 5-bit iteration counter, 16-bit magnitude register, 20-bit BCD shift register, and output registers.

## Test plan
- value=16'd12345, start pulse → done at +17 edges; bcd=20'h12345, neg=0, digit_en=5'b11111.
- value=16'hFFFF (−1) → bcd=20'h00001, neg=1, digit_en=5'b00001. Then value=16'h8000 → bcd=20'h32768, neg=1, digit_en=5'b11111.
- value=0 → bcd=20'h00000, neg=0, digit_en=5'b00001. Then value=16'd907 → bcd=20'h00907, digit_en=5'b00111 (internal zero kept).
- Start at cycle 0 with value=100, extra start at cycle 5 with value=55 → single done; bcd=20'h00100. Start held high across done → second conversion begins in the done cycle, done again 18 cycles later.
- Assert nRST at cycle 8 of a conversion of 16'd999 → next cycle busy=0, bcd=0, digit_en=5'b00001; no done for ≥20 cycles.
- Random 1000 values vs. a reference model: exact match of neg/bcd/digit_en; done width always exactly 1.
